// File: rtl/piano_key_select.sv
// piano_key_select: debounces eight piano keys (A4..A5, A-major scale) and
// selects one note with last-pressed-wins priority. Produces the tone
// counter terminal count (period), a gate (note_on), the selected index and
// a one-cycle pulse whenever the (note_on, note_idx) pair changes.
`timescale 1ns/1ps

module piano_key_select #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  keys,
  output logic [15:0] period,
  output logic        note_on,
  output logic [2:0]  note_idx,
  output logic        note_change
);

  localparam int unsigned NKEYS    = 8;
  localparam int unsigned IDX_W    = 3;
  localparam int unsigned PERIOD_W = 16;
  localparam int unsigned CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_t;

  // Synchronizer, debounce and edge-detect state
  logic [NKEYS-1:0] s1;
  logic [NKEYS-1:0] s2;
  logic [NKEYS-1:0] db;
  logic [NKEYS-1:0] db_d;
  logic [CNT_W-1:0] cnt [NKEYS];
  logic [NKEYS-1:0] press;

  // Selection FSM state and next-state values
  state_t              state;
  state_t              state_nxt;
  logic                note_on_nxt;
  logic [IDX_W-1:0]    note_idx_nxt;
  logic [PERIOD_W-1:0] period_nxt;

  // Previous-cycle copies of the gate/index, used to detect a change
  logic                note_on_d;
  logic [IDX_W-1:0]    note_idx_d;

  // Terminal count for each note of the scale
  function automatic logic [PERIOD_W-1:0] period_rom(input logic [IDX_W-1:0] idx);
    logic [PERIOD_W-1:0] p;
    case (idx)
      3'd0:    p = 16'd56817; // A4
      3'd1:    p = 16'd50618; // B4
      3'd2:    p = 16'd45095; // C#5
      3'd3:    p = 16'd42565; // D5
      3'd4:    p = 16'd37920; // E5
      3'd5:    p = 16'd33783; // F#5
      3'd6:    p = 16'd30097; // G#5
      default: p = 16'd28408; // A5
    endcase
    return p;
  endfunction

  // Index of the highest set bit; zero when no bit is set
  function automatic logic [IDX_W-1:0] highest_idx(input logic [NKEYS-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = 0; i < int'(NKEYS); i++) begin
      if (v[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  // Two-flop synchronizer for the asynchronous buttons
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= keys;
      s2 <= s1;
    end
  end

  // Per-key debounce: accept a change only after it has been stable long enough
  always_ff @(posedge clk) begin
    if (reset) begin
      db <= '0;
      for (int i = 0; i < int'(NKEYS); i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(NKEYS); i++) begin
        if (s2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          db[i]  <= s2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Delayed debounced state for press detection
  always_ff @(posedge clk) begin
    if (reset) begin
      db_d <= '0;
    end else begin
      db_d <= db;
    end
  end

  // Rising edge of each debounced key
  assign press = db & ~db_d;

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and next outputs; a press always beats a release of the current key
  always_comb begin
    state_nxt    = state;
    note_on_nxt  = note_on;
    note_idx_nxt = note_idx;
    period_nxt   = period;
    case (state)
      IDLE: begin
        if (|press) begin
          state_nxt    = PLAY;
          note_on_nxt  = 1'b1;
          note_idx_nxt = highest_idx(press);
          period_nxt   = period_rom(highest_idx(press));
        end
      end
      PLAY: begin
        if (|press) begin
          note_idx_nxt = highest_idx(press);
          period_nxt   = period_rom(highest_idx(press));
        end else if (!db[note_idx]) begin
          if (|db) begin
            note_idx_nxt = highest_idx(db);
            period_nxt   = period_rom(highest_idx(db));
          end else begin
            state_nxt   = IDLE;
            note_on_nxt = 1'b0;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Registered note outputs; period is only loaded together with a new index
  always_ff @(posedge clk) begin
    if (reset) begin
      note_on  <= 1'b0;
      note_idx <= '0;
      period   <= '0;
    end else begin
      note_on  <= note_on_nxt;
      note_idx <= note_idx_nxt;
      period   <= period_nxt;
    end
  end

  // Pulse one cycle after the gate or index changes
  always_ff @(posedge clk) begin
    if (reset) begin
      note_on_d   <= 1'b0;
      note_idx_d  <= '0;
      note_change <= 1'b0;
    end else begin
      note_on_d   <= note_on;
      note_idx_d  <= note_idx;
      note_change <= (note_on != note_on_d) || (note_idx != note_idx_d);
    end
  end

endmodule

// File: tb/tb_piano_key_select.sv
// Directed bench for piano_key_select with a short debounce window.
`timescale 1ns/1ps

module tb_piano_key_select;

  localparam int unsigned DB  = 4;
  localparam int unsigned LAT = DB + 3;

  logic        clk;
  logic        reset;
  logic [7:0]  keys;
  logic [15:0] period;
  logic        note_on;
  logic [2:0]  note_idx;
  logic        note_change;

  int checks;
  int errors;

  piano_key_select #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk         (clk),
    .reset       (reset),
    .keys        (keys),
    .period      (period),
    .note_on     (note_on),
    .note_idx    (note_idx),
    .note_change (note_change)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just past it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance n edges, counting note_change pulses observed
  task automatic run(input int n, output int pulses);
    pulses = 0;
    for (int k = 0; k < n; k++) begin
      tick();
      if (note_change === 1'b1) pulses++;
    end
  endtask

  task automatic test_reset();
    int p;
    reset = 1'b1;
    keys  = 8'h00;
    tick();
    tick();
    checks++;
    if (period !== 16'd0 || note_on !== 1'b0 || note_idx !== 3'd0 || note_change !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: period=%0d on=%0b idx=%0d chg=%0b, expected 0/0/0/0",
               period, note_on, note_idx, note_change);
    end
    reset = 1'b0;
    run(20, p);
    checks++;
    if (p !== 0) begin
      errors++;
      $display("FAIL idle_pulses: got %0d, expected 0", p);
    end
    checks++;
    if (period !== 16'd0 || note_on !== 1'b0) begin
      errors++;
      $display("FAIL idle_outputs: period=%0d on=%0b, expected 0/0", period, note_on);
    end
  endtask

  task automatic test_single_press();
    int p;
    keys = 8'h01;
    run(LAT - 1, p);
    checks++;
    if (note_on !== 1'b0) begin
      errors++;
      $display("FAIL press_early: on=%0b, expected 0", note_on);
    end
    tick();
    checks++;
    if (note_on !== 1'b1 || note_idx !== 3'd0 || period !== 16'd56817 || note_change !== 1'b0) begin
      errors++;
      $display("FAIL press_latency: on=%0b idx=%0d period=%0d chg=%0b, expected 1/0/56817/0",
               note_on, note_idx, period, note_change);
    end
    tick();
    checks++;
    if (note_change !== 1'b1) begin
      errors++;
      $display("FAIL press_pulse: chg=%0b, expected 1", note_change);
    end
    run(5, p);
    checks++;
    if (p !== 0) begin
      errors++;
      $display("FAIL press_pulse_len: extra pulses %0d, expected 0", p);
    end
    keys = 8'h00;
    run(LAT - 1, p);
    checks++;
    if (note_on !== 1'b1) begin
      errors++;
      $display("FAIL release_early: on=%0b, expected 1", note_on);
    end
    tick();
    checks++;
    if (note_on !== 1'b0 || period !== 16'd56817) begin
      errors++;
      $display("FAIL release: on=%0b period=%0d, expected 0/56817", note_on, period);
    end
    run(5, p);
    checks++;
    if (p !== 1) begin
      errors++;
      $display("FAIL release_pulse: got %0d pulses, expected 1", p);
    end
  endtask

  task automatic test_glitch();
    int p;
    keys = 8'h10;
    run(3, p);
    keys = 8'h00;
    run(12, p);
    checks++;
    if (p !== 0 || note_on !== 1'b0 || period !== 16'd56817 || note_idx !== 3'd0) begin
      errors++;
      $display("FAIL glitch: pulses=%0d on=%0b period=%0d idx=%0d, expected 0/0/56817/0",
               p, note_on, period, note_idx);
    end
  endtask

  task automatic test_last_pressed();
    int p;
    int q;
    keys = 8'h40;
    run(LAT, p);
    run(3, q);
    checks++;
    if (note_on !== 1'b1 || note_idx !== 3'd6 || period !== 16'd30097 || p + q !== 1) begin
      errors++;
      $display("FAIL hold6: on=%0b idx=%0d period=%0d pulses=%0d, expected 1/6/30097/1",
               note_on, note_idx, period, p + q);
    end
    keys = 8'h44;
    run(LAT - 1, p);
    checks++;
    if (note_idx !== 3'd6) begin
      errors++;
      $display("FAIL press2_early: idx=%0d, expected 6", note_idx);
    end
    run(1, p);
    run(3, q);
    checks++;
    if (note_idx !== 3'd2 || period !== 16'd45095 || note_on !== 1'b1 || q !== 1) begin
      errors++;
      $display("FAIL press2: idx=%0d period=%0d on=%0b pulses=%0d, expected 2/45095/1/1",
               note_idx, period, note_on, q);
    end
    keys = 8'h40;
    run(LAT, p);
    run(3, q);
    checks++;
    if (note_idx !== 3'd6 || period !== 16'd30097 || note_on !== 1'b1 || p + q !== 1) begin
      errors++;
      $display("FAIL release2: idx=%0d period=%0d on=%0b pulses=%0d, expected 6/30097/1/1",
               note_idx, period, note_on, p + q);
    end
    keys = 8'h00;
    run(LAT, p);
    run(3, q);
    checks++;
    if (note_on !== 1'b0 || period !== 16'd30097 || p + q !== 1) begin
      errors++;
      $display("FAIL release6: on=%0b period=%0d pulses=%0d, expected 0/30097/1",
               note_on, period, p + q);
    end
  endtask

  task automatic test_simultaneous();
    int p;
    int q;
    keys = 8'h88;
    run(LAT, p);
    run(3, q);
    checks++;
    if (note_on !== 1'b1 || note_idx !== 3'd7 || period !== 16'd28408 || p + q !== 1) begin
      errors++;
      $display("FAIL simul: on=%0b idx=%0d period=%0d pulses=%0d, expected 1/7/28408/1",
               note_on, note_idx, period, p + q);
    end
    keys = 8'h80;
    run(12, p);
    checks++;
    if (note_on !== 1'b1 || note_idx !== 3'd7 || period !== 16'd28408 || p !== 0) begin
      errors++;
      $display("FAIL other_release: on=%0b idx=%0d period=%0d pulses=%0d, expected 1/7/28408/0",
               note_on, note_idx, period, p);
    end
    keys = 8'h00;
    run(12, p);
    checks++;
    if (note_on !== 1'b0 || p !== 1) begin
      errors++;
      $display("FAIL simul_off: on=%0b pulses=%0d, expected 0/1", note_on, p);
    end
  endtask

  task automatic test_reset_mid_note();
    int p;
    int q;
    keys = 8'h20;
    run(LAT, p);
    run(3, q);
    checks++;
    if (note_on !== 1'b1 || note_idx !== 3'd5 || period !== 16'd33783) begin
      errors++;
      $display("FAIL play5: on=%0b idx=%0d period=%0d, expected 1/5/33783",
               note_on, note_idx, period);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (period !== 16'd0 || note_on !== 1'b0 || note_idx !== 3'd0 || note_change !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: period=%0d on=%0b idx=%0d chg=%0b, expected 0/0/0/0",
               period, note_on, note_idx, note_change);
    end
    run(LAT - 1, p);
    checks++;
    if (note_on !== 1'b0 || p !== 0) begin
      errors++;
      $display("FAIL replay_early: on=%0b pulses=%0d, expected 0/0", note_on, p);
    end
    tick();
    checks++;
    if (note_on !== 1'b1 || note_idx !== 3'd5 || period !== 16'd33783) begin
      errors++;
      $display("FAIL replay: on=%0b idx=%0d period=%0d, expected 1/5/33783",
               note_on, note_idx, period);
    end
    tick();
    checks++;
    if (note_change !== 1'b1) begin
      errors++;
      $display("FAIL replay_pulse: chg=%0b, expected 1", note_change);
    end
    keys = 8'h00;
    run(12, p);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    keys   = 8'h00;
    test_reset();
    test_single_press();
    test_glitch();
    test_last_pressed();
    test_simultaneous();
    test_reset_mid_note();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
